// File: rtl/uart_pkg.sv
// Shared UART frame definitions: receiver state encoding and line levels.
// Kept in one place so the transmitter and receiver agree on the frame format.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } uart_state_e;

   localparam int   DATA_BITS = 8;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; 2-cycle latency.
// Resets to 1 so an idle-high line never looks like a start bit after reset.
module uart_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_d, meta_q;
   logic sync_d, sync_q;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM, held output byte with pending/ack handshake.
// rx_valid fires 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks after the start edge at rx.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int MSB_FIRST    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 rd_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_pending,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);

   localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   logic rx_s;

   uart_state_e          state_d, state_q;
   logic [CW-1:0]        cnt_d, cnt_q;
   logic [IW-1:0]        idx_d, idx_q;
   logic [DATA_BITS-1:0] shift_d, shift_q;
   logic [DATA_BITS-1:0] data_d, data_q;
   logic                 valid_d, valid_q;
   logic                 pend_d, pend_q;
   logic                 ferr_d, ferr_q;
   logic                 ovr_d, ovr_q;

   uart_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         pend_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         pend_q  <= pend_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      pend_d  = pend_q;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;

      // A good frame below overrides this, so ack and completion together keep pending set.
      if (rd_ack) begin
         pend_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (rx_s == START_LVL) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end
         ST_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               if (rx_s == START_LVL) begin
                  state_d = ST_DATA;
                  idx_d   = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               idx_d = idx_q + IW'(1);
               if (MSB_FIRST != 0) begin
                  shift_d = {shift_q[DATA_BITS-2:0], rx_s};
               end else begin
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               end
               if (idx_q == IDX_LAST) begin
                  state_d = ST_STOP;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               if (rx_s == STOP_LVL) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  ovr_d   = pend_q && !rd_ack;
                  pend_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = ST_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_BREAK: begin
            if (rx_s == STOP_LVL) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign rx_data    = data_q;
   assign rx_valid   = valid_q;
   assign rx_pending = pend_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: one receiver per bit order on a shared line,
// expectations derived from the serial bit sequence actually driven.
module tb_uart_rx;

   localparam int CPB = 16;
   localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

   typedef struct {
      bit         ferr;
      logic [7:0] dat;
      bit         ovr;
      int         cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       rd_ack;
   logic [7:0] rx_data_m, rx_data_l;
   logic       rx_valid_m, rx_valid_l;
   logic       rx_pending_m, rx_pending_l;
   logic       frame_err_m, frame_err_l;
   logic       overrun_m, overrun_l;
   logic       busy_m, busy_l;

   int  tests = 0;
   int  fails = 0;
   int  cyc   = 0;
   ev_t qm[$];
   ev_t ql[$];

   bit         pend;
   logic [7:0] lastm, lastl;

   uart_rx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1)) dut_m (
      .clk(clk), .rst(rst), .rx(rx), .rd_ack(rd_ack),
      .rx_data(rx_data_m), .rx_valid(rx_valid_m), .rx_pending(rx_pending_m),
      .frame_err(frame_err_m), .overrun(overrun_m), .busy(busy_m)
   );

   uart_rx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(0)) dut_l (
      .clk(clk), .rst(rst), .rx(rx), .rd_ack(rd_ack),
      .rx_data(rx_data_l), .rx_valid(rx_valid_l), .rx_pending(rx_pending_l),
      .frame_err(frame_err_l), .overrun(overrun_l), .busy(busy_l)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic mon_chk(input string tag, input logic v, input logic f, input logic o,
                          input logic [7:0] d, input ev_t e);
      chk({tag, " pulses{valid,ferr,ovr}"}, {29'd0, v, f, o},
          e.ferr ? 32'd2 : {29'd0, 1'b1, 1'b0, e.ovr});
      chk({tag, " rx_data"}, {24'd0, d}, {24'd0, e.dat});
      tests++;
      if (cyc > e.cyc + 1 || cyc + 1 < e.cyc) begin
         fails++;
         $display("FAIL %s latency: got cycle %0d, want %0d +-1", tag, cyc, e.cyc);
      end
   endtask

   // Monitor: every output pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (rx_valid_m || frame_err_m || overrun_m) begin
            if (qm.size() == 0) begin
               tests++; fails++;
               $display("FAIL msb unexpected pulse: got v=%b f=%b o=%b, want none", rx_valid_m, frame_err_m, overrun_m);
            end else mon_chk("msb", rx_valid_m, frame_err_m, overrun_m, rx_data_m, qm.pop_front());
         end
         if (rx_valid_l || frame_err_l || overrun_l) begin
            if (ql.size() == 0) begin
               tests++; fails++;
               $display("FAIL lsb unexpected pulse: got v=%b f=%b o=%b, want none", rx_valid_l, frame_err_l, overrun_l);
            end else mon_chk("lsb", rx_valid_l, frame_err_l, overrun_l, rx_data_l, ql.pop_front());
         end
      end
   end

   task automatic ack_pulse();
      rd_ack = 1'b1;
      tick(1);
      rd_ack = 1'b0;
      pend   = 1'b0;
   endtask

   // Drives one frame starting now (just after a posedge). A bad stop bit leaves rx low.
   task automatic send(input logic [7:0] v, input bit msb_ord, input bit stop_ok, input bit ack_end);
      logic [7:0] ser, em, el;
      ev_t        e;
      for (int k = 0; k < 8; k++) ser[k] = msb_ord ? v[7-k] : v[k];
      for (int k = 0; k < 8; k++) begin
         em[7-k] = ser[k];
         el[k]   = ser[k];
      end
      if (stop_ok) begin
         e.ferr = 1'b0;
         e.ovr  = pend && !ack_end;
         pend   = 1'b1;
         lastm  = em;
         lastl  = el;
      end else begin
         e.ferr = 1'b1;
         e.ovr  = 1'b0;
      end
      e.cyc = cyc + LAT;
      e.dat = lastm; qm.push_back(e);
      e.dat = lastl; ql.push_back(e);
      if (ack_end) begin
         fork
            begin
               tick(LAT - 1);
               rd_ack = 1'b1;
               tick(1);
               rd_ack = 1'b0;
            end
         join_none
      end
      rx = 1'b0;
      tick(CPB);
      for (int k = 0; k < 8; k++) begin
         rx = ser[k];
         tick(CPB);
      end
      rx = stop_ok;
      tick(CPB);
   endtask

   initial begin
      rst = 1'b0; rx = 1'b1; rd_ack = 1'b0;
      pend = 1'b0; lastm = 8'h00; lastl = 8'h00;
      tick(3);
      chk("reset outputs msb", {18'd0, rx_data_m, rx_valid_m, rx_pending_m, frame_err_m, overrun_m, busy_m}, 32'd0);
      chk("reset outputs lsb", {18'd0, rx_data_l, rx_valid_l, rx_pending_l, frame_err_l, overrun_l, busy_l}, 32'd0);
      rst = 1'b1;
      tick(3);

      ack_pulse();
      chk("ack without pending", {31'd0, rx_pending_m}, 32'd0);

      send(8'hA5, 1'b1, 1'b1, 1'b0);
      tick(20);
      chk("good byte pending", {31'd0, rx_pending_m}, 32'd1);
      chk("good byte busy", {30'd0, busy_m, busy_l}, 32'd0);
      chk("good byte data", {24'd0, rx_data_m}, 32'hA5);
      ack_pulse();
      chk("ack clears pending", {30'd0, rx_pending_m, rx_pending_l}, 32'd0);

      rx = 1'b0; tick(5); rx = 1'b1; tick(30);
      chk("glitch busy", {30'd0, busy_m, busy_l}, 32'd0);
      chk("glitch data kept", {24'd0, rx_data_m}, {24'd0, lastm});

      send(8'h3C, 1'b1, 1'b0, 1'b0);
      tick(40 - CPB); rx = 1'b1; tick(4);
      chk("ferr data kept", {24'd0, rx_data_m}, {24'd0, lastm});
      send(8'h81, 1'b1, 1'b1, 1'b0);
      tick(10);
      chk("after ferr data", {24'd0, rx_data_m}, 32'h81);
      ack_pulse();

      send(8'h11, 1'b1, 1'b1, 1'b0); tick(5);
      send(8'h22, 1'b1, 1'b1, 1'b0); tick(5);
      chk("overrun data", {24'd0, rx_data_m}, 32'h22);
      send(8'h33, 1'b1, 1'b1, 1'b1); tick(5);
      chk("ack at completion keeps pending", {31'd0, rx_pending_m}, 32'd1);
      ack_pulse();

      send(8'h01, 1'b0, 1'b1, 1'b0);
      send(8'hFE, 1'b0, 1'b1, 1'b0);
      tick(5);
      chk("back-to-back lsb data", {24'd0, rx_data_l}, 32'hFE);
      ack_pulse();
      tick(5);

      rx = 1'b0; tick(CPB * 3);
      rst = 1'b0; #1;
      chk("mid-frame reset msb", {18'd0, rx_data_m, rx_valid_m, rx_pending_m, frame_err_m, overrun_m, busy_m}, 32'd0);
      chk("mid-frame reset lsb", {18'd0, rx_data_l, rx_valid_l, rx_pending_l, frame_err_l, overrun_l, busy_l}, 32'd0);
      rx = 1'b1; pend = 1'b0; lastm = 8'h00; lastl = 8'h00;
      tick(3);
      rst = 1'b1;
      tick(CPB * 12);
      chk("after reset idle", {22'd0, busy_m, busy_l, rx_data_m}, 32'd0);

      for (int i = 0; i < 25; i++) begin
         logic [7:0] v;
         bit         ord, bad;
         int         mode;
         v    = 8'($urandom);
         ord  = 1'($urandom_range(0, 1));
         bad  = ($urandom_range(0, 5) == 0);
         mode = $urandom_range(0, 2);
         send(v, ord, !bad, (mode == 2) && !bad);
         if (bad) begin
            tick($urandom_range(0, 30));
            rx = 1'b1;
            tick(2 + $urandom_range(0, 6));
         end else if (mode == 0) begin
            ack_pulse();
            tick($urandom_range(0, 5));
         end else begin
            tick($urandom_range(0, 3));
         end
      end

      rx = 1'b1;
      tick(CPB * 12);
      chk("msb queue drained", qm.size(), 32'd0);
      chk("lsb queue drained", ql.size(), 32'd0);
      chk("final pending", {30'd0, rx_pending_m, rx_pending_l}, {30'd0, pend, pend});
      chk("final data", {16'd0, rx_data_m, rx_data_l}, {16'd0, lastm, lastl});
      chk("final busy", {30'd0, busy_m, busy_l}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that sits directly downstream of the team's UART transmitter on the same serial line.
- Recovers 8-bit frames: 1 start bit (0), 8 data bits, 1 stop bit (1). Data bits arrive MSB first by default, matching our transmitter.
- Presents each byte as a held register with a 1-cycle valid pulse and a pending/ack handshake to the consumer.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 4..1023 (even values preferred).
- MSB_FIRST, 1, 1 = first data bit received is bit 7; 0 = first is bit 0.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  serial line, asynchronous to clk; idles high.
- rd_ack  in  1  consumer acknowledges rx_data; clears rx_pending.
- rx_data  out  8  last good byte; held until the next good frame.
- rx_valid  out  1  1-cycle pulse when rx_data is updated.
- rx_pending  out  1  set with rx_valid; cleared by rd_ack.
- frame_err  out  1  1-cycle pulse when a stop bit samples 0.
- overrun  out  1  1-cycle pulse when a good frame completes while rx_pending=1 and rd_ack=0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE, synchronizer flops=1, rx_data=0, rx_valid=0, rx_pending=0, frame_err=0, overrun=0, busy=0, all counters=0.
- A reset mid-frame aborts the frame with no output pulses.
- Synchronizer: 2-flop chain rx -> rx_s. All decisions use rx_s only.
- Bit counter cnt has width clog2(CLKS_PER_BIT). Index counter idx is 3 bits.
- IDLE: when rx_s=0 -> START, cnt=0.
- START: count to cnt=CLKS_PER_BIT/2-1 (mid start bit).
  - If rx_s=0: -> DATA, cnt=0, idx=0.
  - Else: glitch; -> IDLE with no pulses.
- DATA: at cnt=CLKS_PER_BIT-1 (mid bit), sample rx_s into the shift register, cnt=0, idx++.
  - MSB_FIRST=1: shift left, inserting at bit 0. MSB_FIRST=0: shift right, inserting at bit 7.
  - After the 8th sample (idx wraps 7->0): -> STOP.
- STOP: at cnt=CLKS_PER_BIT-1, sample rx_s.
  - If 1: rx_data<=shift register, rx_valid=1 for one cycle, rx_pending<=1, -> IDLE.
  - If 0: frame_err=1 for one cycle, rx_data unchanged, rx_pending unchanged, -> BREAK.
- BREAK: wait for rx_s=1, then -> IDLE. This prevents a held-low line from retriggering frames.
- Latency: rx_valid asserts 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks after the start-bit falling edge at the rx pin. For CLKS_PER_BIT=16 that is 155 clocks, ±1 for synchronizer phase.
- Handshake:
  - rd_ack with rx_pending=0 has no effect.
  - Good frame and rd_ack in the same cycle: rx_pending stays 1, no overrun.
  - Good frame while pending and no ack: overrun pulse, rx_data overwritten with the new byte, rx_pending stays 1.
- Output pulses last exactly one cycle and are mutually exclusive with each other except that overrun coincides with rx_valid.
- A back-to-back frame with a start bit right after the stop sample is accepted, because IDLE is re-entered at mid stop bit.

Decomposition:
- Shared package uart_pkg: state encoding (IDLE, START, DATA, STOP, BREAK) and frame constants DATA_BITS=8, START_LVL=0, STOP_LVL=1, so the transmitter can share them.
- One sub-module: uart_sync2, a 2-flop synchronizer with async active-low reset and reset value 1.
- The FSM, counters and output register stay in uart_rx.

Test Plan:
- Reset mid-frame: rst=0 during DATA -> all outputs 0 immediately; state IDLE after release; no rx_valid.
- Good byte: CLKS_PER_BIT=16, send 0xA5 MSB first -> rx_data=0xA5, one rx_valid pulse 155±1 clocks after the falling edge, rx_pending=1, busy returns to 0.
- Glitch: rx low for 5 clocks -> no pulses, state back in IDLE, rx_data unchanged.
- Framing error: send 0x3C with stop bit 0, line held low 40 clocks then high -> frame_err pulse, rx_data keeps its prior value. Then send 0x81 -> rx_data=0x81, rx_valid pulse.
- Overrun: send 0x11 with no ack, then 0x22 -> overrun pulse coincident with rx_valid, rx_data=0x22. Repeat with rd_ack in the completion cycle -> no overrun.
- Back-to-back and LSB mode: MSB_FIRST=0, send 0x01 and 0xFE with zero idle gap -> two rx_valid pulses with rx_data 0x01 then 0xFE.
